// File: rtl/bus_arbiter4.sv
// Four-requester round-robin arbiter driving a one-hot grant and the shared 4:1 mux select.
// Define ARB_TIMEOUT_EN to compile in forced release after MAX_HOLD grant cycles under contention.
module bus_arbiter4 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;

    logic       found;
    logic [1:0] win;

    // Scan starting at ptr so the most recently served requester is searched last.
    always_comb begin
        logic [1:0] idx;
        found = 1'b0;
        win   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             force_rel;

    // A competing request is any request outside the current owner's one-hot grant.
    assign force_rel = (state_q == GRANT) && (cnt_q == HOLD_LAST) && |(req & ~gnt_q);
`else
    logic force_rel;
    assign force_rel = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win;
                    sel_d   = win;
                    busy_d  = 1'b1;
                    ptr_d   = win + 2'd1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    gnt_d  = 4'b0000;
                    busy_d = 1'b0;
                end
            end
            GRANT: begin
                if (done || !req[sel_q] || force_rel) begin
                    // sel is left alone so the mux output stays stable while idle.
                    state_d   = IDLE;
                    gnt_d     = 4'b0000;
                    busy_d    = 1'b0;
                    timeout_d = force_rel && !done && req[sel_q];
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            sel_q     <= 2'd0;
            gnt_q     <= 4'b0000;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4 with MAX_HOLD=4; expectations follow ARB_TIMEOUT_EN.
module tb_bus_arbiter4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    bus_arbiter4 #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic b, input logic t);
        check({tag, ".gnt"}, {4'b0, gnt}, {4'b0, g});
        check({tag, ".sel"}, {6'b0, sel}, {6'b0, s});
        check({tag, ".busy"}, {7'b0, busy}, {7'b0, b});
        check({tag, ".timeout"}, {7'b0, timeout}, {7'b0, t});
    endtask

    initial begin
        // Reset state
        #2;
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // Single requester 2, done after 3 more grant cycles
        req = 4'b0100;
        tick();
        check_out("r2_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("r2_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        done = 1'b1;
        tick();
        check_out("r2_release", 4'b0000, 2'd2, 1'b0, 1'b0);
        done = 1'b0;
        req  = 4'b0000;
        tick();
        check_out("r2_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

        // All four requesting: rotation 0,1,2,3 with a bubble between grants
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_out("rr_grant", 4'b0001 << k, 2'(k), 1'b1, 1'b0);
            done = 1'b1;
            tick();
            check_out("rr_bubble", 4'b0000, 2'(k), 1'b0, 1'b0);
            done = 1'b0;
        end

        // Pointer wraps past 3: 0 wins, then 3
        req = 4'b1001;
        tick();
        check_out("wrap_first", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b1000;
        tick();
        check_out("wrap_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b1001;
        tick();
        check_out("wrap_second", 4'b1000, 2'd3, 1'b1, 1'b0);
        // Non-owner request during GRANT is ignored
        req = 4'b1011;
        tick();
        check_out("nonowner", 4'b1000, 2'd3, 1'b1, 1'b0);
        // done with owner deassert gives one release
        done = 1'b1;
        req  = 4'b0000;
        tick();
        check_out("dual_rel", 4'b0000, 2'd3, 1'b0, 1'b0);
        // done in IDLE is ignored
        tick();
        check_out("done_idle", 4'b0000, 2'd3, 1'b0, 1'b0);
        done = 1'b0;

        // Asynchronous reset mid-grant; ptr returns to 0
        req = 4'b0010;
        tick();
        check_out("pre_rst", 4'b0010, 2'd1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        req = 4'b1010;
        tick();
        check_out("post_rst", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        check_out("post_rst_rel", 4'b0000, 2'd1, 1'b0, 1'b0);

        // Contention from requester 2 while owner 0 holds without done
        do_reset();
        req = 4'b0101;
        tick();
        check_out("to_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("to_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        tick();
        check_out("to_force", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        check_out("to_next", 4'b0100, 2'd2, 1'b1, 1'b0);
`else
        for (int i = 0; i < 8; i++) begin
            tick();
            check_out("no_to_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`endif
        req = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
